// File: rtl/axi_pkg.sv
// Shared definitions for the IFU/LSU AXI4 arbiter: read FSM states, master IDs,
// and AXI burst/response encodings.
package axi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_IFU_RD = 2'd1,
      ST_LSU_RD = 2'd2
   } rd_state_e;

   localparam logic [3:0] IFU_ID = 4'd0;
   localparam logic [3:0] LSU_ID = 4'd1;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic logic [3:0] master_id(input logic is_lsu);
      return is_lsu ? LSU_ID : IFU_ID;
   endfunction

endpackage

// File: rtl/axi_arb_pick.sv
// Combinational read-grant selection between IFU and LSU.
// AXI_ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise LSU wins.
module axi_arb_pick (
`ifdef AXI_ARB_ROUND_ROBIN_EN
   input  logic i_last_lsu,
`endif
   input  logic i_req_ifu,
   input  logic i_req_lsu,
   output logic o_grant_valid,
   output logic o_grant_lsu
);

   // Pick a winner among the eligible requesters
   always_comb begin
      o_grant_valid = i_req_ifu | i_req_lsu;
      case ({i_req_lsu, i_req_ifu})
         2'b11: begin
`ifdef AXI_ARB_ROUND_ROBIN_EN
            o_grant_lsu = ~i_last_lsu;
`else
            o_grant_lsu = 1'b1;
`endif
         end
         2'b10:   o_grant_lsu = 1'b1;
         default: o_grant_lsu = 1'b0;
      endcase
   end

endmodule

// File: rtl/axi_arbiter.sv
// Two-master (IFU, LSU) to one AXI4 slave arbiter: single-outstanding locked reads,
// LSU writes passed straight through. AXI_ARB_ROUND_ROBIN_EN enables round-robin reads.
module axi_arbiter
   import axi_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clock,
   input  logic                reset,
   // IFU read
   input  logic                ifu_arvalid,
   output logic                ifu_arready,
   input  logic [ADDR_W-1:0]   ifu_araddr,
   input  logic [7:0]          ifu_arlen,
   input  logic [2:0]          ifu_arsize,
   input  logic [1:0]          ifu_arburst,
   output logic                ifu_rvalid,
   input  logic                ifu_rready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic [1:0]          ifu_rresp,
   output logic                ifu_rlast,
   // LSU read
   input  logic                lsu_arvalid,
   output logic                lsu_arready,
   input  logic [ADDR_W-1:0]   lsu_araddr,
   input  logic [7:0]          lsu_arlen,
   input  logic [2:0]          lsu_arsize,
   input  logic [1:0]          lsu_arburst,
   output logic                lsu_rvalid,
   input  logic                lsu_rready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic [1:0]          lsu_rresp,
   output logic                lsu_rlast,
   // LSU write
   input  logic                lsu_awvalid,
   output logic                lsu_awready,
   input  logic [ADDR_W-1:0]   lsu_awaddr,
   input  logic [7:0]          lsu_awlen,
   input  logic [2:0]          lsu_awsize,
   input  logic [1:0]          lsu_awburst,
   input  logic                lsu_wvalid,
   output logic                lsu_wready,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   input  logic                lsu_wlast,
   output logic                lsu_bvalid,
   input  logic                lsu_bready,
   output logic [1:0]          lsu_bresp,
   // Downstream master
   output logic                io_master_arvalid,
   input  logic                io_master_arready,
   output logic [3:0]          io_master_arid,
   output logic [ADDR_W-1:0]   io_master_araddr,
   output logic [7:0]          io_master_arlen,
   output logic [2:0]          io_master_arsize,
   output logic [1:0]          io_master_arburst,
   input  logic                io_master_rvalid,
   output logic                io_master_rready,
   input  logic [3:0]          io_master_rid,
   input  logic [DATA_W-1:0]   io_master_rdata,
   input  logic [1:0]          io_master_rresp,
   input  logic                io_master_rlast,
   output logic                io_master_awvalid,
   input  logic                io_master_awready,
   output logic [3:0]          io_master_awid,
   output logic [ADDR_W-1:0]   io_master_awaddr,
   output logic [7:0]          io_master_awlen,
   output logic [2:0]          io_master_awsize,
   output logic [1:0]          io_master_awburst,
   output logic                io_master_wvalid,
   input  logic                io_master_wready,
   output logic [DATA_W-1:0]   io_master_wdata,
   output logic [DATA_W/8-1:0] io_master_wstrb,
   output logic                io_master_wlast,
   input  logic                io_master_bvalid,
   output logic                io_master_bready,
   input  logic [3:0]          io_master_bid,
   input  logic [1:0]          io_master_bresp
);

   rd_state_e r_state;
   rd_state_e w_rd_sel;
   logic      r_ar_done;
   logic      r_wr_busy;
   logic      w_aw_fire, w_b_fire, w_wr_busy_nxt;
   logic      w_ar_fire, w_r_last_fire;
   logic      w_req_lsu, w_grant_valid, w_grant_lsu;
   logic      w_unused_ids;
`ifdef AXI_ARB_ROUND_ROBIN_EN
   logic      r_last_lsu;
`endif

   assign w_unused_ids = ^{io_master_rid, io_master_bid};

   // Write path is a straight pass-through, held quiet while in reset
   assign io_master_awvalid = lsu_awvalid & ~reset;
   assign lsu_awready       = io_master_awready & ~reset;
   assign io_master_awid    = LSU_ID;
   assign io_master_awaddr  = lsu_awaddr;
   assign io_master_awlen   = lsu_awlen;
   assign io_master_awsize  = lsu_awsize;
   assign io_master_awburst = lsu_awburst;
   assign io_master_wvalid  = lsu_wvalid & ~reset;
   assign lsu_wready        = io_master_wready & ~reset;
   assign io_master_wdata   = lsu_wdata;
   assign io_master_wstrb   = lsu_wstrb;
   assign io_master_wlast   = lsu_wlast;
   assign lsu_bvalid        = io_master_bvalid & ~reset;
   assign io_master_bready  = lsu_bready & ~reset;
   assign lsu_bresp         = io_master_bresp;

   assign w_aw_fire     = io_master_awvalid & io_master_awready;
   assign w_b_fire      = io_master_bvalid & io_master_bready;
   // Looking at next-cycle busy lets an LSU read win in the B-handshake cycle,
   // and blocks it in the AW-handshake cycle
   assign w_wr_busy_nxt = w_aw_fire | (r_wr_busy & ~w_b_fire);
   assign w_req_lsu     = lsu_arvalid & ~w_wr_busy_nxt;

   assign w_ar_fire     = io_master_arvalid & io_master_arready;
   assign w_r_last_fire = io_master_rvalid & io_master_rready & io_master_rlast;
   assign w_rd_sel      = reset ? ST_IDLE : r_state;

   axi_arb_pick u_pick (
`ifdef AXI_ARB_ROUND_ROBIN_EN
      .i_last_lsu    (r_last_lsu),
`endif
      .i_req_ifu     (ifu_arvalid),
      .i_req_lsu     (w_req_lsu),
      .o_grant_valid (w_grant_valid),
      .o_grant_lsu   (w_grant_lsu)
   );

   // Read FSM: grant in IDLE, hold until the last beat handshakes
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_ar_done <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ar_done <= 1'b0;
               if (w_grant_valid) begin
                  r_state <= w_grant_lsu ? ST_LSU_RD : ST_IFU_RD;
               end
            end
            ST_IFU_RD, ST_LSU_RD: begin
               if (w_ar_fire) begin
                  r_ar_done <= 1'b1;
               end
               if (w_r_last_fire) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_ar_done <= 1'b0;
            end
         endcase
      end
   end

   // Outstanding-write flag; a set in the same cycle as a clear wins
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_busy <= 1'b0;
      end else begin
         r_wr_busy <= w_wr_busy_nxt;
      end
   end

`ifdef AXI_ARB_ROUND_ROBIN_EN
   // Remember who was granted last for round-robin
   always_ff @(posedge clock) begin
      if (reset) begin
         r_last_lsu <= 1'b0;
      end else if ((r_state == ST_IDLE) && w_grant_valid) begin
         r_last_lsu <= w_grant_lsu;
      end
   end
`endif

   // AR forwarding and R routing to the granted master only; AR is shut off
   // after its handshake so a second request waits for IDLE
   always_comb begin
      io_master_arvalid = 1'b0;
      io_master_arid    = master_id(1'b0);
      io_master_araddr  = ifu_araddr;
      io_master_arlen   = ifu_arlen;
      io_master_arsize  = ifu_arsize;
      io_master_arburst = ifu_arburst;
      io_master_rready  = 1'b0;
      ifu_arready       = 1'b0;
      lsu_arready       = 1'b0;
      ifu_rvalid        = 1'b0;
      ifu_rdata         = {DATA_W{1'b0}};
      ifu_rresp         = 2'b00;
      ifu_rlast         = 1'b0;
      lsu_rvalid        = 1'b0;
      lsu_rdata         = {DATA_W{1'b0}};
      lsu_rresp         = 2'b00;
      lsu_rlast         = 1'b0;
      case (w_rd_sel)
         ST_IFU_RD: begin
            io_master_arvalid = ifu_arvalid & ~r_ar_done;
            ifu_arready       = io_master_arready & ~r_ar_done;
            io_master_rready  = ifu_rready;
            ifu_rvalid        = io_master_rvalid;
            ifu_rdata         = io_master_rdata;
            ifu_rresp         = io_master_rresp;
            ifu_rlast         = io_master_rlast;
         end
         ST_LSU_RD: begin
            io_master_arvalid = lsu_arvalid & ~r_ar_done;
            lsu_arready       = io_master_arready & ~r_ar_done;
            io_master_arid    = master_id(1'b1);
            io_master_araddr  = lsu_araddr;
            io_master_arlen   = lsu_arlen;
            io_master_arsize  = lsu_arsize;
            io_master_arburst = lsu_arburst;
            io_master_rready  = lsu_rready;
            lsu_rvalid        = io_master_rvalid;
            lsu_rdata         = io_master_rdata;
            lsu_rresp         = io_master_rresp;
            lsu_rlast         = io_master_rlast;
         end
         default: begin
            io_master_arvalid = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all AR/AW channels.
REQ-002 SHALL have parameter DATA_W, default 32, data width of R/W channels.
REQ-003 SHALL have port clock, input, 1, system clock; all state updates on posedge clock.
REQ-004 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port group ifu_ar{valid,ready,addr,len,size,burst}, in/out per AXI4, 1/1/ADDR_W/8/3/2, IFU read-address channel.
REQ-006 SHALL have port group ifu_r{valid,ready,data,resp,last}, out/in per AXI4, 1/1/DATA_W/2/1, IFU read-data channel.
REQ-007 SHALL have port groups lsu_ar*, lsu_r*, with the same widths as REQ-005/006, LSU read channels.
REQ-008 SHALL have port groups lsu_aw{valid,ready,addr,len,size,burst}, lsu_w{valid,ready,data,strb,last}, lsu_b{valid,ready,resp}, with AXI4 widths, LSU write channels.
REQ-009 SHALL have port group io_master_* with the full AXI4 master set (ar/r/aw/w/b plus arid/awid 4 bits, rid/bid 4 bits), downstream port to the memory/device slave.

Function
REQ-010 SHALL implement a read FSM with states IDLE, IFU_RD and LSU_RD.
REQ-011 In IDLE, SHALL drive io_master_arvalid=0 and ifu_arready=lsu_arready=0.
REQ-012 In IDLE with an eligible arvalid, SHALL register the grant and move to IFU_RD or LSU_RD; AR is presented downstream one cycle after request.
REQ-013 LSU read SHALL be ineligible while wr_busy=1, giving read-after-write ordering.
REQ-014 When both masters are eligible in the same cycle, SHALL pick per REQ-030/031.
REQ-015 In a granted state, SHALL forward the granted master's AR fields and arvalid, and return io_master_arready to that master only.
REQ-016 SHALL drive io_master_arid to 0 for IFU and 1 for LSU.
REQ-017 SHALL route R data/resp/last/valid only to the granted master; the non-granted master sees rvalid=0.
REQ-018 SHALL drive io_master_rready from the granted master's rready.
REQ-019 SHALL return to IDLE in the cycle after the handshake where rvalid&rready&rlast; bursts up to len=255 stay locked.
REQ-020 SHALL allow one outstanding read; a second AR from the same master SHALL stall until IDLE.
REQ-021 SHALL pass the LSU AW/W/B channels combinationally to io_master, with awid=1.
REQ-022 SHALL set wr_busy on aw handshake and clear it on b handshake; a simultaneous set and clear SHALL leave it set.
REQ-023 A read and a write SHALL proceed concurrently unless REQ-013 applies.

Reset
REQ-024 On reset, SHALL force the FSM to IDLE, wr_busy=0 and last_grant=IFU.
REQ-025 During reset, all valid/ready outputs SHALL be 0.
REQ-026 A burst in flight at reset SHALL be abandoned without completing it.

Configuration
REQ-030 With AXI_ARB_ROUND_ROBIN_EN defined, SHALL grant the master not in last_grant on contention; last_grant updates on each grant.
REQ-031 Without AXI_ARB_ROUND_ROBIN_EN, SHALL use fixed priority LSU over IFU; last_grant is not implemented.

Structure
REQ-032 SHALL put the FSM state enum, master ID constants (IFU_ID=0, LSU_ID=1) and AXI burst/resp constants in the shared package axi_pkg.
REQ-033 SHALL contain one sub-module, axi_arb_pick, for combinational grant selection (the fixed/RR choice).

Verification
REQ-034 IFU arvalid, addr 0x80000000, len 0, with no LSU request -> io_master_arvalid high next cycle with arid=0; ifu_r gets rdata, and lsu_rvalid stays 0.
REQ-035 IFU and LSU arvalid in the same cycle, RR disabled -> LSU granted first; IFU granted after the LSU rlast.
REQ-036 Same stimulus as REQ-035 repeated twice with RR enabled -> grants alternate LSU, IFU, LSU, IFU.
REQ-037 IFU burst len=3 at 0x80000000 with LSU arvalid mid-burst -> four beats to IFU at addrs +0/+4/+8/+C; LSU AR not forwarded until after rlast.
REQ-038 LSU AW to 0xa00003f8 with bready held 0 and LSU AR pending -> LSU AR blocked; AR forwarded the cycle after the B handshake.
REQ-039 Reset asserted during beat 2 of a len=3 burst -> state IDLE and all valids 0 the cycle after; a new IFU AR is then accepted normally.
